// File: rtl/z80_bus_dma.sv
// Z80 bus-master DMA engine: requests the CPU bus, copies a block of bytes
// memory-to-memory with optional fixed (port-style) source or destination,
// then hands the bus back and pulses done.
//
// state | meaning
// IDLE  | waiting for start; transfer parameters captured on start
// REQ   | nBUSRQ asserted, waiting for nBUSACK
// RD1   | source address out, nMREQ and nRD asserted
// RD2   | read strobes held; stretched by nWAIT and the RD_WAIT counter
// RD3   | read data latched, read strobes released
// WR1   | destination address and data out, nMREQ asserted
// WR2   | nWR asserted; stretched by nWAIT
// WR3   | write strobes released; addresses and byte count stepped
// REL   | nBUSRQ released, waiting for nBUSACK to go high
// DONE  | one-cycle completion pulse
module z80_bus_dma #(
    parameter int RD_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    input  logic        src_fix,
    input  logic        dst_fix,
    output logic        busy,
    output logic        done,
    output logic        nBUSRQ,
    input  logic        nBUSACK,
    input  logic        nWAIT,
    output logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        bus_en,
    output logic        nMREQ,
    output logic        nRD,
    output logic        nWR
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] REQ  = 4'd1;
    localparam logic [3:0] RD1  = 4'd2;
    localparam logic [3:0] RD2  = 4'd3;
    localparam logic [3:0] RD3  = 4'd4;
    localparam logic [3:0] WR1  = 4'd5;
    localparam logic [3:0] WR2  = 4'd6;
    localparam logic [3:0] WR3  = 4'd7;
    localparam logic [3:0] REL  = 4'd8;
    localparam logic [3:0] DONE = 4'd9;

    localparam int WAIT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_WAIT);

    logic [3:0]        state;
    logic [3:0]        stateNext;
    logic [15:0]       srcAddr;
    logic [15:0]       dstAddr;
    // 17 bits so that len=0 loads 65536
    logic [16:0]       remaining;
    logic              srcFixed;
    logic              dstFixed;
    logic [7:0]        dataReg;
    logic [WAIT_W-1:0] waitCnt;
    logic              busReqN;
    logic              holdBusNext;

    // Next-state decode
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = REQ;
            REQ:  if (!nBUSACK) stateNext = RD1;
            RD1:  stateNext = RD2;
            RD2:  if (nWAIT && (waitCnt == '0)) stateNext = RD3;
            RD3:  stateNext = WR1;
            WR1:  stateNext = WR2;
            WR2:  if (nWAIT) stateNext = WR3;
            WR3:  stateNext = (remaining == 17'd1) ? REL : RD1;
            REL:  if (nBUSACK) stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign holdBusNext = stateNext inside {REQ, RD1, RD2, RD3, WR1, WR2, WR3};

    // State, transfer registers and the bus request flop
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            srcAddr   <= 16'h0000;
            dstAddr   <= 16'h0000;
            remaining <= 17'd0;
            srcFixed  <= 1'b0;
            dstFixed  <= 1'b0;
            dataReg   <= 8'h00;
            waitCnt   <= '0;
            busReqN   <= 1'b1;
        end else begin
            state <= stateNext;
            // nBUSRQ goes straight to the CPU, so it comes from a flop
            // loaded with the next state's value rather than a decode.
            busReqN <= !holdBusNext;

            if ((state == IDLE) && start) begin
                srcAddr   <= src;
                dstAddr   <= dst;
                remaining <= (len == 16'h0000) ? 17'h10000 : {1'b0, len};
                srcFixed  <= src_fix;
                dstFixed  <= dst_fix;
            end

            if (stateNext == RD1) begin
                waitCnt <= WAIT_LOAD;
            end else if ((state == RD2) && (waitCnt != '0)) begin
                waitCnt <= waitCnt - 1'b1;
            end

            if (state == RD3) begin
                dataReg <= D_in;
            end

            if (state == WR3) begin
                if (!srcFixed) srcAddr <= srcAddr + 16'd1;
                if (!dstFixed) dstAddr <= dstAddr + 16'd1;
                remaining <= remaining - 17'd1;
            end
        end
    end

    // Bus strobes, address and data-enable decoded from the current state
    always_comb begin
        A      = 16'h0000;
        nMREQ  = 1'b1;
        nRD    = 1'b1;
        nWR    = 1'b1;
        D_oe   = 1'b0;
        bus_en = 1'b0;
        case (state)
            RD1, RD2: begin
                A      = srcAddr;
                nMREQ  = 1'b0;
                nRD    = 1'b0;
                bus_en = 1'b1;
            end
            RD3: begin
                A      = srcAddr;
                bus_en = 1'b1;
            end
            WR1: begin
                A      = dstAddr;
                nMREQ  = 1'b0;
                D_oe   = 1'b1;
                bus_en = 1'b1;
            end
            WR2: begin
                A      = dstAddr;
                nMREQ  = 1'b0;
                nWR    = 1'b0;
                D_oe   = 1'b1;
                bus_en = 1'b1;
            end
            WR3: begin
                A      = dstAddr;
                D_oe   = 1'b1;
                bus_en = 1'b1;
            end
            default: begin
                A = 16'h0000;
            end
        endcase
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign nBUSRQ = busReqN;
    assign D_out  = dataReg;

endmodule

// File: tb/tb_z80_bus_dma.sv
// Bench for z80_bus_dma: a ROM-style memory feeding D_in, a Z80 bus-grant
// model, an nWAIT generator and a write/read monitor, with expected traffic
// computed from the transfer parameters.
module tb_z80_bus_dma;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        src_fix;
    logic        dst_fix;
    logic        busy;
    logic        done;
    logic        nBUSRQ;
    logic        nBUSACK = 1'b1;
    logic        nWAIT = 1'b1;
    logic [15:0] A;
    logic [7:0]  D_in;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        bus_en;
    logic        nMREQ;
    logic        nRD;
    logic        nWR;

    int checks = 0;
    int failures = 0;

    logic [7:0] romImage [0:65535];
    assign D_in = romImage[A];

    // Environment settings, written by the test sequence
    int grantDelay = 2;
    int waitByte = -1;
    int rdWaitN = 0;
    int wrWaitN = 0;

    // Monitor-owned observations
    int cycleCnt = 0;
    int busEnCount = 0;
    int doneCount = 0;
    int readCount = 0;
    int violations = 0;
    int rdLow = 0;
    int wrLow = 0;
    logic prevNRd = 1'b1;
    logic prevNWr = 1'b1;
    logic [15:0] wrA = 16'h0000;
    logic [7:0]  wrD = 8'h00;
    logic [7:0]  busHist = 8'hFF;
    logic [15:0] rdAddrQ[$];
    logic [15:0] wrAddrQ[$];
    logic [7:0]  wrDataQ[$];
    int          rdFallCycle[$];

    // Expected traffic and snapshot bases, owned by the test sequence
    logic [15:0] expRdQ[$];
    logic [15:0] expWrQ[$];
    logic [7:0]  expDatQ[$];
    int rdBase, wrBase, beBase, dnBase, viBase;

    always #5 clock = ~clock;

    z80_bus_dma #(.RD_WAIT(0)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .src_fix (src_fix),
        .dst_fix (dst_fix),
        .busy    (busy),
        .done    (done),
        .nBUSRQ  (nBUSRQ),
        .nBUSACK (nBUSACK),
        .nWAIT   (nWAIT),
        .A       (A),
        .D_in    (D_in),
        .D_out   (D_out),
        .D_oe    (D_oe),
        .bus_en  (bus_en),
        .nMREQ   (nMREQ),
        .nRD     (nRD),
        .nWR     (nWR)
    );

    // Bus observer, memory-write capture, nWAIT generator and Z80 grant model
    always @(negedge clock) begin
        cycleCnt++;
        if (bus_en) busEnCount++;
        if (done) doneCount++;
        if ((!nRD && !nWR) || (D_oe && !nRD) || (!nMREQ && !bus_en)) violations++;
        if (prevNRd && !nRD) begin
            rdAddrQ.push_back(A);
            rdFallCycle.push_back(cycleCnt);
            readCount++;
        end
        if (!nWR) begin
            wrA = A;
            wrD = D_out;
        end
        if (!prevNWr && nWR && bus_en) begin
            wrAddrQ.push_back(wrA);
            wrDataQ.push_back(wrD);
        end
        prevNRd = nRD;
        prevNWr = nWR;
        rdLow = nRD ? 0 : rdLow + 1;
        wrLow = nWR ? 0 : wrLow + 1;
        nWAIT = !((readCount == waitByte) &&
                  ((rdLow >= 2 && rdLow <= rdWaitN + 1) || (wrLow >= 1 && wrLow <= wrWaitN)));
        busHist = {busHist[6:0], nBUSRQ};
        nBUSACK = busHist[grantDelay - 1];
    end

    // Reference: the bytes a block copy must read and write, in order
    task automatic modelTransfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                                 input logic sf, input logic df);
        int n;
        logic [15:0] ra;
        logic [15:0] wa;
        expRdQ.delete();
        expWrQ.delete();
        expDatQ.delete();
        n = (l == 16'h0000) ? 65536 : int'(l);
        for (int i = 0; i < n; i++) begin
            ra = sf ? s : s + 16'(i);
            wa = df ? d : d + 16'(i);
            expRdQ.push_back(ra);
            expWrQ.push_back(wa);
            expDatQ.push_back(romImage[ra]);
        end
    endtask

    task automatic snapshot();
        rdBase = rdAddrQ.size();
        wrBase = wrAddrQ.size();
        beBase = busEnCount;
        dnBase = doneCount;
        viBase = violations;
    endtask

    task automatic waitDone(input int budget, output logic timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                timedOut = 1'b0;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic runTransfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                               input logic sf, input logic df, input int budget, output logic timedOut);
        @(posedge clock); #1;
        src = s; dst = d; len = l; src_fix = sf; dst_fix = df; start = 1'b1;
        snapshot();
        @(posedge clock); #1;
        start = 1'b0;
        waitDone(budget, timedOut);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({nBUSRQ, nMREQ, nRD, nWR, D_oe, bus_en, busy, done} !== 8'b1111_0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, want 11110000", {nBUSRQ, nMREQ, nRD, nWR, D_oe, bus_en, busy, done});
        end
        checks++;
        if (A !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h, want 0000", A); end
        checks++;
        if (D_out !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h, want 00", D_out); end
        reset = 1'b0;
    endtask

    task automatic test_copy4();
        logic timedOut;
        logic [7:0] expData [4];
        expData = '{8'h11, 8'h22, 8'h33, 8'h44};
        romImage[16'h1000] = 8'h11;
        romImage[16'h1001] = 8'h22;
        romImage[16'h1002] = 8'h33;
        romImage[16'h1003] = 8'h44;
        grantDelay = 2;
        @(posedge clock); #1;
        src = 16'h1000; dst = 16'h2000; len = 16'd4; src_fix = 1'b0; dst_fix = 1'b0; start = 1'b1;
        snapshot();
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if ({busy, nBUSRQ} !== 2'b10) begin
            failures++;
            $display("FAIL copy4_latency: busy,nBUSRQ got %b, want 10", {busy, nBUSRQ});
        end
        waitDone(200, timedOut);
        checks++;
        if (timedOut !== 1'b0) begin failures++; $display("FAIL copy4_timeout: no done within 200 cycles"); end
        checks++;
        if (busEnCount - beBase !== 24) begin
            failures++; $display("FAIL copy4_busen: got %0d cycles, want 24", busEnCount - beBase);
        end
        checks++;
        if (doneCount - dnBase !== 1) begin
            failures++; $display("FAIL copy4_done: got %0d pulses, want 1", doneCount - dnBase);
        end
        checks++;
        if ({busy, nBUSRQ} !== 2'b01) begin
            failures++; $display("FAIL copy4_idle: busy,nBUSRQ got %b, want 01", {busy, nBUSRQ});
        end
        checks++;
        if (wrAddrQ.size() - wrBase !== 4) begin
            failures++; $display("FAIL copy4_count: got %0d writes, want 4", wrAddrQ.size() - wrBase);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rdAddrQ[rdBase + i] !== 16'h1000 + 16'(i) || wrAddrQ[wrBase + i] !== 16'h2000 + 16'(i) ||
                    wrDataQ[wrBase + i] !== expData[i]) begin
                    failures++;
                    $display("FAIL copy4_byte%0d: rd %h wr %h data %h, want rd %h wr %h data %h", i,
                             rdAddrQ[rdBase + i], wrAddrQ[wrBase + i], wrDataQ[wrBase + i],
                             16'h1000 + 16'(i), 16'h2000 + 16'(i), expData[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic timedOut;
        modelTransfer(16'hFFFE, 16'h0010, 16'd3, 1'b0, 1'b0);
        runTransfer(16'hFFFE, 16'h0010, 16'd3, 1'b0, 1'b0, 200, timedOut);
        checks++;
        if (timedOut !== 1'b0 || wrAddrQ.size() - wrBase !== 3) begin
            failures++; $display("FAIL wrap_count: timeout %b writes %0d, want 0 and 3", timedOut, wrAddrQ.size() - wrBase);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rdAddrQ[rdBase + i] !== expRdQ[i] || wrAddrQ[wrBase + i] !== expWrQ[i] ||
                    wrDataQ[wrBase + i] !== expDatQ[i]) begin
                    failures++;
                    $display("FAIL wrap_byte%0d: rd %h wr %h data %h, want rd %h wr %h data %h", i,
                             rdAddrQ[rdBase + i], wrAddrQ[wrBase + i], wrDataQ[wrBase + i],
                             expRdQ[i], expWrQ[i], expDatQ[i]);
                end
            end
        end
    endtask

    task automatic test_fixed();
        logic timedOut;
        modelTransfer(16'h0080, 16'h3000, 16'd2, 1'b1, 1'b0);
        runTransfer(16'h0080, 16'h3000, 16'd2, 1'b1, 1'b0, 200, timedOut);
        checks++;
        if (timedOut !== 1'b0 || wrAddrQ.size() - wrBase !== 2) begin
            failures++; $display("FAIL fixed_count: timeout %b writes %0d, want 0 and 2", timedOut, wrAddrQ.size() - wrBase);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rdAddrQ[rdBase + i] !== expRdQ[i] || wrAddrQ[wrBase + i] !== expWrQ[i] ||
                    wrDataQ[wrBase + i] !== expDatQ[i]) begin
                    failures++;
                    $display("FAIL fixed_byte%0d: rd %h wr %h data %h, want rd %h wr %h data %h", i,
                             rdAddrQ[rdBase + i], wrAddrQ[wrBase + i], wrDataQ[wrBase + i],
                             expRdQ[i], expWrQ[i], expDatQ[i]);
                end
            end
        end
    endtask

    task automatic test_waits();
        logic timedOut;
        int firstByte;
        int secondByte;
        modelTransfer(16'h3100, 16'h3200, 16'd3, 1'b0, 1'b0);
        waitByte = readCount + 2;
        rdWaitN = 3;
        wrWaitN = 2;
        runTransfer(16'h3100, 16'h3200, 16'd3, 1'b0, 1'b0, 200, timedOut);
        waitByte = -1;
        checks++;
        if (busEnCount - beBase !== 23) begin
            failures++; $display("FAIL waits_busen: got %0d cycles, want 23", busEnCount - beBase);
        end
        checks++;
        if (timedOut !== 1'b0 || rdFallCycle.size() - rdBase !== 3) begin
            failures++; $display("FAIL waits_count: timeout %b reads %0d, want 0 and 3", timedOut, rdFallCycle.size() - rdBase);
        end else begin
            firstByte = rdFallCycle[rdBase + 1] - rdFallCycle[rdBase];
            secondByte = rdFallCycle[rdBase + 2] - rdFallCycle[rdBase + 1];
            checks++;
            if (firstByte !== 6) begin failures++; $display("FAIL waits_byte1_len: got %0d, want 6", firstByte); end
            checks++;
            if (secondByte !== 11) begin failures++; $display("FAIL waits_byte2_len: got %0d, want 11", secondByte); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wrAddrQ[wrBase + i] !== expWrQ[i] || wrDataQ[wrBase + i] !== expDatQ[i]) begin
                    failures++;
                    $display("FAIL waits_byte%0d: wr %h data %h, want wr %h data %h", i,
                             wrAddrQ[wrBase + i], wrDataQ[wrBase + i], expWrQ[i], expDatQ[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic timedOut;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] l;
        logic sf;
        logic df;
        for (int t = 0; t < 6; t++) begin
            s = 16'($urandom);
            d = 16'($urandom);
            l = 16'($urandom_range(1, 10));
            sf = 1'($urandom);
            df = 1'($urandom);
            grantDelay = $urandom_range(1, 4);
            modelTransfer(s, d, l, sf, df);
            runTransfer(s, d, l, sf, df, 400, timedOut);
            checks++;
            if (timedOut !== 1'b0 || busEnCount - beBase !== 6 * int'(l) || doneCount - dnBase !== 1 ||
                violations - viBase !== 0) begin
                failures++;
                $display("FAIL random%0d_shape: timeout %b busen %0d done %0d viol %0d, want 0 %0d 1 0", t,
                         timedOut, busEnCount - beBase, doneCount - dnBase, violations - viBase, 6 * int'(l));
            end
            checks++;
            if (wrAddrQ.size() - wrBase !== int'(l)) begin
                failures++; $display("FAIL random%0d_count: got %0d writes, want %0d", t, wrAddrQ.size() - wrBase, l);
            end else begin
                for (int i = 0; i < int'(l); i++) begin
                    checks++;
                    if (rdAddrQ[rdBase + i] !== expRdQ[i] || wrAddrQ[wrBase + i] !== expWrQ[i] ||
                        wrDataQ[wrBase + i] !== expDatQ[i]) begin
                        failures++;
                        $display("FAIL random%0d_byte%0d: rd %h wr %h data %h, want rd %h wr %h data %h", t, i,
                                 rdAddrQ[rdBase + i], wrAddrQ[wrBase + i], wrDataQ[wrBase + i],
                                 expRdQ[i], expWrQ[i], expDatQ[i]);
                    end
                end
            end
        end
        grantDelay = 2;
    endtask

    task automatic test_abort();
        logic reached;
        logic pw;
        int wrEntries;
        romImage[16'h4000] = 8'hA1;
        romImage[16'h4001] = 8'hB2;
        romImage[16'h4002] = 8'hC3;
        romImage[16'h4003] = 8'hD4;
        @(posedge clock); #1;
        src = 16'h4000; dst = 16'h5000; len = 16'd4; src_fix = 1'b0; dst_fix = 1'b0; start = 1'b1;
        snapshot();
        @(posedge clock); #1;
        start = 1'b0;
        reached = 1'b0;
        pw = 1'b1;
        wrEntries = 0;
        for (int i = 0; i < 200; i++) begin
            if (!nWR && pw) wrEntries++;
            pw = nWR;
            if (wrEntries == 2) begin
                reached = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        checks++;
        if (reached !== 1'b1) begin failures++; $display("FAIL abort_reach: second WR2 not seen in 200 cycles"); end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({nWR, nBUSRQ, bus_en, busy, done} !== 5'b11000) begin
            failures++; $display("FAIL abort_ctrl: nWR,nBUSRQ,bus_en,busy,done got %b, want 11000", {nWR, nBUSRQ, bus_en, busy, done});
        end
        checks++;
        if (D_out !== 8'h00 || A !== 16'h0000) begin
            failures++; $display("FAIL abort_regs: D_out %h A %h, want 00 0000", D_out, A);
        end
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        checks++;
        if (doneCount - dnBase !== 0) begin
            failures++; $display("FAIL abort_done: got %0d pulses, want 0", doneCount - dnBase);
        end
        checks++;
        if (wrAddrQ.size() - wrBase !== 1) begin
            failures++; $display("FAIL abort_writes: got %0d writes, want 1", wrAddrQ.size() - wrBase);
        end else begin
            checks++;
            if (wrAddrQ[wrBase] !== 16'h5000 || wrDataQ[wrBase] !== 8'hA1) begin
                failures++; $display("FAIL abort_byte1: wr %h data %h, want 5000 a1", wrAddrQ[wrBase], wrDataQ[wrBase]);
            end
        end
    endtask

    task automatic test_start_rules();
        logic timedOut;
        // start pulses while busy must not disturb the running transfer
        modelTransfer(16'h6000, 16'h6100, 16'd2, 1'b0, 1'b0);
        @(posedge clock); #1;
        src = 16'h6000; dst = 16'h6100; len = 16'd2; src_fix = 1'b0; dst_fix = 1'b0; start = 1'b1;
        snapshot();
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        src = 16'h7777; dst = 16'h7800; len = 16'd5; src_fix = 1'b1; dst_fix = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        waitDone(200, timedOut);
        checks++;
        if (timedOut !== 1'b0 || doneCount - dnBase !== 1 || wrAddrQ.size() - wrBase !== 2) begin
            failures++;
            $display("FAIL busy_start_shape: timeout %b done %0d writes %0d, want 0 1 2", timedOut,
                     doneCount - dnBase, wrAddrQ.size() - wrBase);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wrAddrQ[wrBase + i] !== expWrQ[i] || wrDataQ[wrBase + i] !== expDatQ[i]) begin
                    failures++;
                    $display("FAIL busy_start_byte%0d: wr %h data %h, want wr %h data %h", i,
                             wrAddrQ[wrBase + i], wrDataQ[wrBase + i], expWrQ[i], expDatQ[i]);
                end
            end
        end
        // start held through DONE is only taken in the following IDLE cycle
        runTransfer(16'h6200, 16'h6300, 16'd1, 1'b0, 1'b0, 0, timedOut);
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            @(posedge clock); #1;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL done_hold_reach: done got %b, want 1", done); end
        src = 16'h6400; dst = 16'h6500; len = 16'd2; src_fix = 1'b0; dst_fix = 1'b0; start = 1'b1;
        modelTransfer(16'h6400, 16'h6500, 16'd2, 1'b0, 1'b0);
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL done_start_ignored: busy got %b, want 0", busy); end
        snapshot();
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL idle_start_taken: busy got %b, want 1", busy); end
        waitDone(200, timedOut);
        checks++;
        if (timedOut !== 1'b0 || doneCount - dnBase !== 1 || wrAddrQ.size() - wrBase !== 2) begin
            failures++;
            $display("FAIL restart_shape: timeout %b done %0d writes %0d, want 0 1 2", timedOut,
                     doneCount - dnBase, wrAddrQ.size() - wrBase);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wrAddrQ[wrBase + i] !== expWrQ[i] || wrDataQ[wrBase + i] !== expDatQ[i]) begin
                    failures++;
                    $display("FAIL restart_byte%0d: wr %h data %h, want wr %h data %h", i,
                             wrAddrQ[wrBase + i], wrDataQ[wrBase + i], expWrQ[i], expDatQ[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        src = 16'h0000;
        dst = 16'h0000;
        len = 16'h0000;
        src_fix = 1'b0;
        dst_fix = 1'b0;
        for (int i = 0; i < 65536; i++) romImage[i] = 8'($urandom);
        test_reset();
        test_copy4();
        test_wrap();
        test_fixed();
        test_waits();
        test_random();
        test_abort();
        test_start_rules();
        checks++;
        if (violations !== 0) begin
            failures++; $display("FAIL bus_protocol: got %0d strobe violations, want 0", violations);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
